// File: rtl/mem8x8_arbiter_if.sv
// Bus bundle between the mem8x8 arbiter, its two requesters and the 8x8 memory array.
// The arbiter takes the slave view; clients and the memory together form the master side.
interface mem8x8_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic       we_a;
  logic       we_b;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [7:0] wdata_a;
  logic [7:0] wdata_b;
  logic       ack_a;
  logic       ack_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       busy;
  logic [2:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_select;
  logic       mem_rw;
  logic [7:0] mem_data_out;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_data_out,
    input  ack_a, ack_b, rdata_a, rdata_b, busy, mem_address, mem_data_in, mem_select, mem_rw
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_data_out,
    output ack_a, ack_b, rdata_a, rdata_b, busy, mem_address, mem_data_in, mem_select, mem_rw
  );
endinterface

// File: rtl/mem8x8_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 8x8 memory array.
// Each grant runs SETUP -> ACCESS -> DONE with every output registered.
module mem8x8_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input logic            clk,
  input logic            rst_n,
  mem8x8_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [3:0] SetupLoad  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] AccessLoad = 4'(ACCESS_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic       win_b_q, win_b_d;
  logic       last_b_q, last_b_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic [7:0] rdata_a_q, rdata_a_d;
  logic [7:0] rdata_b_q, rdata_b_d;
  logic       busy_q, busy_d;
  // mem_address/mem_data_in registers double as the latched request.
  logic [2:0] mem_address_q, mem_address_d;
  logic [7:0] mem_data_in_q, mem_data_in_d;
  logic       mem_select_q, mem_select_d;
  logic       mem_rw_q, mem_rw_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    win_b_d       = win_b_q;
    last_b_d      = last_b_q;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    rdata_a_d     = rdata_a_q;
    rdata_b_d     = rdata_b_q;
    busy_d        = busy_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_select_d  = mem_select_q;
    mem_rw_d      = mem_rw_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_a || bus.req_b) begin
          // On a tie the port not served last wins.
          win_b_d       = bus.req_b && (!bus.req_a || !last_b_q);
          we_d          = win_b_d ? bus.we_b    : bus.we_a;
          mem_address_d = win_b_d ? bus.addr_b  : bus.addr_a;
          mem_data_in_d = win_b_d ? bus.wdata_b : bus.wdata_a;
          mem_select_d  = 1'b1;
          mem_rw_d      = 1'b0;
          busy_d        = 1'b1;
          cnt_d         = SetupLoad;
          state_d       = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          mem_rw_d = we_q;
          cnt_d    = AccessLoad;
          state_d  = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          mem_rw_d = 1'b0;
          last_b_d = win_b_q;
          ack_a_d  = !win_b_q;
          ack_b_d  = win_b_q;
          if (!we_q && win_b_q)  rdata_b_d = bus.mem_data_out;
          if (!we_q && !win_b_q) rdata_a_d = bus.mem_data_out;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        mem_select_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      we_q          <= 1'b0;
      win_b_q       <= 1'b0;
      last_b_q      <= 1'b1;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      rdata_a_q     <= 8'h00;
      rdata_b_q     <= 8'h00;
      busy_q        <= 1'b0;
      mem_address_q <= 3'd0;
      mem_data_in_q <= 8'h00;
      mem_select_q  <= 1'b0;
      mem_rw_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      win_b_q       <= win_b_d;
      last_b_q      <= last_b_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      rdata_a_q     <= rdata_a_d;
      rdata_b_q     <= rdata_b_d;
      busy_q        <= busy_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_select_q  <= mem_select_d;
      mem_rw_q      <= mem_rw_d;
    end
  end

  assign bus.ack_a       = ack_a_q;
  assign bus.ack_b       = ack_b_q;
  assign bus.rdata_a     = rdata_a_q;
  assign bus.rdata_b     = rdata_b_q;
  assign bus.busy        = busy_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.mem_select  = mem_select_q;
  assign bus.mem_rw      = mem_rw_q;

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// Bench for mem8x8_arbiter: two instances (default timing and SETUP=3/ACCESS=2), each with
// a memory stand-in and a transaction-level model compared on every falling edge.
module tb_mem8x8_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic [1:0]      req_a = '0, req_b = '0, we_a = '0, we_b = '0;
  logic [1:0][2:0] addr_a = '0, addr_b = '0;
  logic [1:0][7:0] wdata_a = '0, wdata_b = '0;
  logic [1:0]      ack_a, ack_b, busy, sel, rw;
  logic [1:0][7:0] rdata_a, rdata_b;
  logic [1:0][2:0] maddr;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_cfg
    localparam int S = (g == 0) ? 1 : 3;
    localparam int A = (g == 0) ? 1 : 2;

    mem8x8_arbiter_if bus ();
    logic [7:0] mem_arr [8];

    mem8x8_arbiter #(.SETUP_CYCLES(S), .ACCESS_CYCLES(A)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.req_a   = req_a[g];
    assign bus.req_b   = req_b[g];
    assign bus.we_a    = we_a[g];
    assign bus.we_b    = we_b[g];
    assign bus.addr_a  = addr_a[g];
    assign bus.addr_b  = addr_b[g];
    assign bus.wdata_a = wdata_a[g];
    assign bus.wdata_b = wdata_b[g];
    assign ack_a[g]    = bus.ack_a;
    assign ack_b[g]    = bus.ack_b;
    assign busy[g]     = bus.busy;
    assign sel[g]      = bus.mem_select;
    assign rw[g]       = bus.mem_rw;
    assign rdata_a[g]  = bus.rdata_a;
    assign rdata_b[g]  = bus.rdata_b;
    assign maddr[g]    = bus.mem_address;

    // Memory stand-in; cleared while reset is held so contents stay deterministic.
    assign bus.mem_data_out = bus.mem_select ? mem_arr[bus.mem_address] : 8'h00;
    always @(posedge clk) begin
      if (!rst_n) for (int i = 0; i < 8; i++) mem_arr[i] <= 8'h00;
      else if (bus.mem_select && bus.mem_rw) mem_arr[bus.mem_address] <= bus.mem_data_in;
    end

    // Transaction model: k counts edges since the grant edge.
    bit         act = 1'b0;
    int         k = 0;
    bit         port_b = 1'b0, t_we = 1'b0, last_b = 1'b1;
    logic [2:0] t_addr = '0;
    logic [7:0] t_wd = '0, exp_ra = '0, exp_rb = '0;
    logic [7:0] mmem [8];

    initial begin
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          act = 1'b0; last_b = 1'b1; exp_ra = '0; exp_rb = '0;
          t_addr = '0; t_wd = '0;
          for (int i = 0; i < 8; i++) mmem[i] = 8'h00;
        end else if (act) begin
          k++;
          if (k == S + A) begin
            if (t_we) mmem[t_addr] = t_wd;
            else if (port_b) exp_rb = mmem[t_addr];
            else exp_ra = mmem[t_addr];
            last_b = port_b;
          end
          if (k == S + A + 1) act = 1'b0;
        end else if (req_a[g] || req_b[g]) begin
          port_b = req_b[g] && (!req_a[g] || !last_b);
          t_we   = port_b ? we_b[g]    : we_a[g];
          t_addr = port_b ? addr_b[g]  : addr_a[g];
          t_wd   = port_b ? wdata_b[g] : wdata_a[g];
          act    = 1'b1;
          k      = 0;
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          check($sformatf("rst_busy%0d", g), bus.busy, 0);
          check($sformatf("rst_sel%0d", g), bus.mem_select, 0);
          check($sformatf("rst_rw%0d", g), bus.mem_rw, 0);
          check($sformatf("rst_acks%0d", g), {bus.ack_a, bus.ack_b}, 0);
          check($sformatf("rst_rdata%0d", g), {bus.rdata_a, bus.rdata_b}, 0);
          check($sformatf("rst_addr%0d", g), bus.mem_address, 0);
          check($sformatf("rst_din%0d", g), bus.mem_data_in, 0);
        end else begin
          check($sformatf("busy%0d", g), bus.busy, act);
          check($sformatf("sel%0d", g), bus.mem_select, act);
          check($sformatf("rw%0d", g), bus.mem_rw, act && t_we && k >= S && k < S + A);
          check($sformatf("ack_a%0d", g), bus.ack_a, act && k == S + A && !port_b);
          check($sformatf("ack_b%0d", g), bus.ack_b, act && k == S + A && port_b);
          check($sformatf("rdata_a%0d", g), bus.rdata_a, exp_ra);
          check($sformatf("rdata_b%0d", g), bus.rdata_b, exp_rb);
          if (act) begin
            check($sformatf("addr%0d", g), bus.mem_address, t_addr);
            check($sformatf("din%0d", g), bus.mem_data_in, t_wd);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Single-port transaction; edges counts the grant edge as 1.
  task automatic run_txn(input int g, input bit pb, input bit we, input logic [2:0] addr,
                         input logic [7:0] wd, input bit chg, output int edges, output int rwc,
                         output int pre, output logic [7:0] rd, output logic [2:0] ad);
    bit got = 1'b0;
    edges = 0; rwc = 0; pre = 0; rd = '0; ad = '0;
    if (pb) begin req_b[g] = 1'b1; we_b[g] = we; addr_b[g] = addr; wdata_b[g] = wd; end
    else    begin req_a[g] = 1'b1; we_a[g] = we; addr_a[g] = addr; wdata_a[g] = wd; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      #1;
      if (chg && edges == 1) begin
        if (pb) addr_b[g] = 3'd5;
        else    addr_a[g] = 3'd5;
      end
      if (rw[g]) rwc++;
      else if (sel[g] && rwc == 0) pre++;
      if (pb ? ack_b[g] : ack_a[g]) begin
        got = 1'b1;
        rd  = pb ? rdata_b[g] : rdata_a[g];
        ad  = maddr[g];
      end
    end
    req_a[g] = 1'b0;
    req_b[g] = 1'b0;
    if (!got) check("txn_timeout", 0, 1);
    step();
  endtask

  int ord [4];
  int at_edge [4];

  task automatic run_both(input bit wa, input logic [2:0] aa, input logic [7:0] da,
                          input logic [2:0] ab, input int n, input bit drop_each);
    int nack = 0;
    int e = 0;
    req_a[0] = 1'b1; we_a[0] = wa; addr_a[0] = aa; wdata_a[0] = da;
    req_b[0] = 1'b1; we_b[0] = 1'b0; addr_b[0] = ab; wdata_b[0] = 8'h00;
    for (int i = 0; i < 80 && nack < n; i++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      #1;
      if (ack_a[0] || ack_b[0]) begin
        ord[nack]     = int'(ack_b[0]);
        at_edge[nack] = e;
        nack++;
        if (drop_each) begin
          if (ack_a[0]) req_a[0] = 1'b0;
          else          req_b[0] = 1'b0;
        end
      end
    end
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    if (nack < n) check("both_timeout", nack, n);
    step();
  endtask

  initial begin
    int edges, rwc, pre;
    logic [7:0] rd;
    logic [2:0] ad;

    step();
    step();
    rst_n = 1'b1;
    step();
    check("init_busy", busy, 2'b00);
    check("init_sel_rw", {sel, rw}, 4'b0000);
    check("init_rdata", {rdata_a, rdata_b}, 32'h0);

    // Default timing: A writes 0xAA to 0, then reads it back.
    run_txn(0, 1'b0, 1'b1, 3'd0, 8'hAA, 1'b0, edges, rwc, pre, rd, ad);
    check("wr_edges", edges, 3);
    check("wr_rw_cycles", rwc, 1);
    run_txn(0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, edges, rwc, pre, rd, ad);
    check("rd_edges", edges, 3);
    check("rd_data", rd, 8'hAA);
    check("rd_rw_cycles", rwc, 0);

    // Simultaneous requests after reset: A (write 0x55 @3) before B (read @3).
    do_reset();
    run_both(1'b1, 3'd3, 8'h55, 3'd3, 2, 1'b1);
    check("tie_first", ord[0], 0);
    check("tie_second", ord[1], 1);
    check("tie_spacing", at_edge[1] - at_edge[0], 4);
    check("tie_rdata_b", rdata_b[0], 8'h55);

    // Both held for four transactions: strict alternation, 4 cycles apart.
    run_both(1'b0, 3'd3, 8'h00, 3'd3, 4, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), ord[i], i % 2);
    for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), at_edge[i] - at_edge[i-1], 4);
    check("rr_edge0", at_edge[0], 3);

    // Address changed during SETUP must not affect the read in flight.
    run_txn(0, 1'b0, 1'b1, 3'd2, 8'h22, 1'b0, edges, rwc, pre, rd, ad);
    run_txn(0, 1'b0, 1'b1, 3'd5, 8'h99, 1'b0, edges, rwc, pre, rd, ad);
    run_txn(0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1, edges, rwc, pre, rd, ad);
    check("chg_addr_done", ad, 3'd2);
    check("chg_rdata", rd, 8'h22);

    // Long setup/access instance.
    run_txn(1, 1'b0, 1'b1, 3'd4, 8'h3C, 1'b0, edges, rwc, pre, rd, ad);
    check("p_wr_edges", edges, 6);
    check("p_wr_rw_cycles", rwc, 2);
    check("p_wr_setup", pre, 3);
    run_txn(1, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0, edges, rwc, pre, rd, ad);
    check("p_rd_edges", edges, 6);
    check("p_rd_data", rd, 8'h3C);

    // Reset during ACCESS of a write.
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 3'd7; wdata_a[0] = 8'h77;
    step();
    step();
    check("mid_rw_before", rw[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid_rw_async", rw[0], 0);
    check("mid_sel_async", sel[0], 0);
    check("mid_busy_async", busy[0], 0);
    req_a[0] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    begin
      int nacks = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (ack_a[0] || ack_b[0]) nacks++;
      end
      check("mid_no_ack", nacks, 0);
    end
    check("mid_rdata_a", rdata_a[0], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
